// File: rtl/dh_key_encrypt.sv
// Diffie-Hellman key derivation (MSB-first square-and-multiply, k = base^exp mod m)
// followed by nibble encryption c = msg ^ k; one modular multiply per cycle.
module dh_key_encrypt #(
  parameter int unsigned W = 4,
  parameter int unsigned E = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] base_i,
  input  logic [E-1:0] exp_i,
  input  logic [W-1:0] mod_i,
  input  logic [W-1:0] msg_i,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] k_o,
  output logic [W-1:0] c_o
);

  localparam int unsigned IW = (E > 1) ? $clog2(E) : 1;

  typedef enum logic [2:0] {StIdle, StLoad, StSqr, StMul, StFin} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   base_q, base_d;
  logic [W-1:0]   mod_q, mod_d;
  logic [W-1:0]   msg_q, msg_d;
  logic [E-1:0]   exp_q, exp_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic [W-1:0]   k_q, k_d;
  logic [W-1:0]   c_q, c_d;
  logic           done_q, done_d;

  logic [2*W-1:0] op_a, op_b, prod, divisor, rem;

  // Shared multiplier/reducer: LOAD reduces base (base*1 mod m), SQR squares, MUL multiplies by b.
  always_comb begin
    op_a = {{W{1'b0}}, acc_q};
    op_b = {{W{1'b0}}, acc_q};
    if (state_q == StLoad) begin
      op_a = {{W{1'b0}}, base_q};
      op_b = {{(2*W-1){1'b0}}, 1'b1};
    end else if (state_q == StMul) begin
      op_b = {{W{1'b0}}, b_q};
    end
    prod = op_a * op_b;
    // m=0 never reaches the reducer's consumers; keep the divide well defined anyway.
    divisor = (mod_q == '0) ? {{(2*W-1){1'b0}}, 1'b1} : {{W{1'b0}}, mod_q};
    rem     = prod % divisor;
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    mod_d   = mod_q;
    msg_d   = msg_q;
    exp_d   = exp_q;
    b_d     = b_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    k_d     = k_q;
    c_d     = c_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          base_d  = base_i;
          exp_d   = exp_i;
          mod_d   = mod_i;
          msg_d   = msg_i;
          state_d = StLoad;
        end
      end
      StLoad: begin
        if (mod_q[W-1:1] == '0) begin
          acc_d   = '0;
          state_d = StFin;
        end else begin
          acc_d   = W'(1);
          b_d     = rem[W-1:0];
          idx_d   = IW'(E - 1);
          state_d = StSqr;
        end
      end
      StSqr: begin
        acc_d = rem[W-1:0];
        if (exp_q[idx_q]) begin
          state_d = StMul;
        end else if (idx_q == '0) begin
          state_d = StFin;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      StMul: begin
        acc_d = rem[W-1:0];
        if (idx_q == '0) begin
          state_d = StFin;
        end else begin
          idx_d   = idx_q - IW'(1);
          state_d = StSqr;
        end
      end
      StFin: begin
        k_d     = acc_q;
        c_d     = acc_q ^ msg_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      mod_q   <= '0;
      msg_q   <= '0;
      exp_q   <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      k_q     <= '0;
      c_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      mod_q   <= mod_d;
      msg_q   <= msg_d;
      exp_q   <= exp_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      k_q     <= k_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != StIdle);
  assign done = done_q;
  assign k_o  = k_q;
  assign c_o  = c_q;

endmodule

// File: tb/tb_dh_key_encrypt.sv
// Scoreboard bench for dh_key_encrypt: stimulus pushes expected key/cipher/done-cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_dh_key_encrypt;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] base_i, exp_i, mod_i, msg_i;
  logic       busy, done;
  logic [3:0] k_o, c_o;

  dh_key_encrypt #(.W(4), .E(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .base_i (base_i),
    .exp_i  (exp_i),
    .mod_i  (mod_i),
    .msg_i  (msg_i),
    .busy   (busy),
    .done   (done),
    .k_o    (k_o),
    .c_o    (c_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int k;
    int c;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b1 && done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("k_o", int'(k_o), mon_e.k);
        chk("c_o", int'(c_o), mon_e.c);
        chk("done_cycle", cyc, mon_e.cyc);
        chk("busy_low_at_done", int'(busy), 0);
      end
    end
  end

  // Call at a negedge; the next posedge accepts the start.
  task automatic issue(input int b, input int x, input int m, input int g,
                       input int k, input int c, input int lat);
    exp_t e;
    base_i = 4'(b);
    exp_i  = 4'(x);
    mod_i  = 4'(m);
    msg_i  = 4'(g);
    start  = 1'b1;
    e.k    = k;
    e.c    = c;
    e.cyc  = cyc + 1 + lat;
    sb.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("done_timeout", 0, 1);
  endtask

  initial begin
    rst    = 1'b0;
    start  = 1'b0;
    base_i = '0;
    exp_i  = '0;
    mod_i  = '0;
    msg_i  = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_k", int'(k_o), 0);
    chk("rst_c", int'(c_o), 0);
    rst = 1'b1;
    @(negedge clk);

    // 3^5 mod 11 = 1, latency 4+2+2
    issue(3, 5, 11, 4'hA, 1, 4'hB, 8);
    wait_drain();
    // 7^15 mod 13 = 5, latency 4+4+2
    issue(7, 15, 13, 4'h5, 5, 4'h0, 10);
    wait_drain();
    // base 14 reduced to 4, 4^2 mod 5 = 1
    issue(14, 2, 5, 4'h3, 1, 4'h2, 7);
    wait_drain();
    // exp=0 -> k=1; degenerate moduli -> k=0, c=msg, latency 2
    issue(3, 0, 7, 4'h6, 1, 4'h7, 6);
    wait_drain();
    issue(3, 0, 1, 4'h6, 0, 4'h6, 2);
    wait_drain();
    issue(9, 9, 0, 4'h5, 0, 4'h5, 2);
    wait_drain();

    // Start and input changes while busy are ignored; start in the done cycle is accepted.
    issue(7, 15, 13, 4'h5, 5, 4'h0, 10);
    repeat (2) @(negedge clk);
    base_i = 4'd3;
    exp_i  = 4'd5;
    mod_i  = 4'd11;
    msg_i  = 4'hA;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    base_i = 4'd1;
    mod_i  = 4'd2;
    wait_done();
    issue(14, 2, 5, 4'h3, 1, 4'h2, 7);
    wait_drain();

    // Reset mid-run: outputs clear, no done, clean restart.
    issue(3, 5, 11, 4'hA, 1, 4'hB, 8);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_k", int'(k_o), 0);
    chk("midrst_c", int'(c_o), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    chk("idle_after_rst", int'(busy), 0);
    issue(3, 5, 11, 4'hA, 1, 4'hB, 8);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
